// File: rtl/game_pkg.sv
// Shared types and constants for the air-hockey scoreboard game-state logic.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int SCORE_W   = 7;
  localparam int SCORE_SAT = 99;
  localparam int PAUSE_W   = 4;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;
  localparam logic [1:0] WINNER_DRAW  = 2'b11;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_SAT)) ? SCORE_W'(SCORE_SAT) : s + SCORE_W'(1);
  endfunction

  function automatic logic [1:0] winner_of(input logic [SCORE_W-1:0] l,
                                           input logic [SCORE_W-1:0] r);
    if (l > r)      return WINNER_LEFT;
    else if (r > l) return WINNER_RIGHT;
    else            return WINNER_DRAW;
  endfunction

endpackage

// File: rtl/score_timer_ctrl_sec_tick_gen.sv
// Game-second prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count_reg;

  assign tick = (count_reg == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_reg <= '0;
    else if (clr || tick)
      count_reg <= '0;
    else
      count_reg <= count_reg + CNT_W'(1);
  end

endmodule

// File: rtl/score_timer_ctrl.sv
// Match state for the air-hockey scoreboard: goal counters, countdown clock,
// post-goal freeze and winner decision, all presented as registered outputs.
module score_timer_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int GAME_SECONDS  = 60,
  parameter int PAUSE_SECONDS = 2,
  parameter int WIN_SCORE     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               goal_l,
  input  logic               goal_r,
  output logic [SCORE_W-1:0] lscore,
  output logic [SCORE_W-1:0] rscore,
  output logic [SCORE_W-1:0] timecount,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         winner
);

  game_state_t        state_reg;
  logic               start_q_reg;
  logic [PAUSE_W-1:0] pause_cnt_reg;
  logic               start_rise;
  logic               tick;
  logic [SCORE_W-1:0] lscore_next;
  logic [SCORE_W-1:0] rscore_next;
  logic [SCORE_W-1:0] time_next;
  logic               match_end;

  assign start_rise = start & ~start_q_reg;

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_sec_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_rise),
    .tick (tick)
  );

  // Candidate PLAY-state values; only committed while in PLAY.
  always_comb begin
    time_next   = (tick && timecount != '0) ? timecount - SCORE_W'(1) : timecount;
    lscore_next = goal_l ? score_inc(lscore) : lscore;
    rscore_next = goal_r ? score_inc(rscore) : rscore;
    match_end   = (time_next == '0) ||
                  (lscore_next >= SCORE_W'(WIN_SCORE)) ||
                  (rscore_next >= SCORE_W'(WIN_SCORE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      start_q_reg   <= 1'b0;
      pause_cnt_reg <= '0;
      lscore        <= '0;
      rscore        <= '0;
      timecount     <= '0;
      playing       <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WINNER_NONE;
    end else begin
      start_q_reg <= start;
      // A start press restarts the match from any state.
      if (start_rise) begin
        state_reg     <= ST_PLAY;
        pause_cnt_reg <= '0;
        lscore        <= '0;
        rscore        <= '0;
        timecount     <= SCORE_W'(GAME_SECONDS);
        playing       <= 1'b1;
        game_over     <= 1'b0;
        winner        <= WINNER_NONE;
      end else begin
        case (state_reg)
          ST_PLAY: begin
            timecount <= time_next;
            lscore    <= lscore_next;
            rscore    <= rscore_next;
            if (match_end) begin
              state_reg <= ST_OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
              winner    <= winner_of(lscore_next, rscore_next);
            end else if (goal_l || goal_r) begin
              state_reg     <= ST_PAUSE;
              pause_cnt_reg <= PAUSE_W'(PAUSE_SECONDS);
            end
          end
          ST_PAUSE: begin
            if (tick) begin
              pause_cnt_reg <= pause_cnt_reg - PAUSE_W'(1);
              if (pause_cnt_reg <= PAUSE_W'(1))
                state_reg <= ST_PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_timer_ctrl.sv
// Scoreboard bench for score_timer_ctrl: a cycle model queues expected outputs, DUT results are popped and compared.
module tb_score_timer_ctrl;

  localparam int TD = 4;
  localparam int GS = 10;
  localparam int PS = 2;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       goal_l;
  logic       goal_r;
  logic [6:0] lscore;
  logic [6:0] rscore;
  logic [6:0] timecount;
  logic       playing;
  logic       game_over;
  logic [1:0] winner;

  score_timer_ctrl #(
    .TICK_DIV     (TD),
    .GAME_SECONDS (GS),
    .PAUSE_SECONDS(PS),
    .WIN_SCORE    (WS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .goal_l   (goal_l),
    .goal_r   (goal_r),
    .lscore   (lscore),
    .rscore   (rscore),
    .timecount(timecount),
    .playing  (playing),
    .game_over(game_over),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] l;
    logic [6:0] r;
    logic [6:0] t;
    logic       p;
    logic       o;
    logic [1:0] w;
  } exp_t;

  exp_t q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Reference model state: 0 idle, 1 play, 2 pause, 3 over
  int m_st, m_l, m_r, m_t, m_pc, m_cnt, m_sq, m_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    tests_run++;
    if (obs !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_l = 0; m_r = 0; m_t = 0; m_pc = 0; m_cnt = 0; m_sq = 0; m_win = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.l = 7'(m_l);
    e.r = 7'(m_r);
    e.t = 7'(m_t);
    e.p = (m_st == 1 || m_st == 2);
    e.o = (m_st == 3);
    e.w = 2'(m_win);
    return e;
  endfunction

  task automatic model_step(input bit s, input bit gl, input bit gr);
    bit rise;
    bit tk;
    rise  = s && (m_sq == 0);
    tk    = (m_cnt == TD - 1);
    m_cnt = (rise || tk) ? 0 : m_cnt + 1;
    m_sq  = s;
    if (rise) begin
      m_st = 1; m_l = 0; m_r = 0; m_t = GS; m_win = 0; m_pc = 0;
    end else if (m_st == 1) begin
      if (tk && m_t > 0) m_t = m_t - 1;
      if (gl) m_l = (m_l < 99) ? m_l + 1 : 99;
      if (gr) m_r = (m_r < 99) ? m_r + 1 : 99;
      if (m_t == 0 || m_l >= WS || m_r >= WS) begin
        m_st  = 3;
        m_win = (m_l > m_r) ? 1 : (m_r > m_l) ? 2 : 3;
      end else if (gl || gr) begin
        m_st = 2; m_pc = PS;
      end
    end else if (m_st == 2 && tk) begin
      m_pc = m_pc - 1;
      if (m_pc == 0) m_st = 1;
    end
  endtask

  task automatic cycle(input bit s, input bit gl, input bit gr);
    exp_t e;
    @(negedge clk);
    start  = s;
    goal_l = gl;
    goal_r = gr;
    model_step(s, gl, gr);
    q.push_back(model_out());
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("cycle", {lscore, rscore, timecount, playing, game_over, winner}, e);
    $display("[TB] s=%0b gl=%0b gr=%0b -> l=%0d r=%0d t=%0d p=%0b o=%0b w=%0d",
             s, gl, gr, lscore, rscore, timecount, playing, game_over, winner);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; goal_l = 1'b0; goal_r = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {lscore, rscore, timecount, playing, game_over, winner}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: start -> PLAY, three ticks in 12 cycles
    cycle(1, 0, 0);
    chk("t1_playing", playing, 1);
    chk("t1_time", timecount, GS);
    repeat (12) cycle(0, 0, 0);
    chk("t1_time12", timecount, 7);

    // 2: goal_l, two-tick freeze, goal_r ignored while paused
    cycle(0, 1, 0);
    chk("t2_lscore", lscore, 1);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 1);
    repeat (2) cycle(0, 0, 0);
    chk("t2_rscore_ign", rscore, 0);
    repeat (4) cycle(0, 0, 0);
    chk("t2_frozen", timecount, 7);
    cycle(0, 0, 0);
    chk("t2_resumed", timecount, 6);

    // 3: simultaneous goals after restart
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    chk("t3_lscore", lscore, 1);
    chk("t3_rscore", rscore, 1);
    chk("t3_playing", playing, 1);

    // 4: run out the clock -> draw, then OVER is frozen
    repeat (60) cycle(0, 0, 0);
    chk("t4_over", game_over, 1);
    chk("t4_winner", winner, 2'b11);
    chk("t4_playing", playing, 0);
    chk("t4_time", timecount, 0);
    cycle(0, 1, 0);
    repeat (5) cycle(0, 0, 0);
    chk("t4_lfrozen", lscore, 1);
    chk("t4_tfrozen", timecount, 0);

    // 5: right wins on its third goal, then restart
    cycle(1, 0, 0);
    chk("t5_restart", {lscore, rscore, timecount}, {7'd0, 7'd0, 7'(GS)});
    cycle(0, 0, 1);
    repeat (9) cycle(0, 0, 0);
    cycle(0, 0, 1);
    repeat (9) cycle(0, 0, 0);
    chk("t5_r2", rscore, 2);
    chk("t5_not_over", game_over, 0);
    cycle(0, 0, 1);
    chk("t5_r3", rscore, 3);
    chk("t5_over", game_over, 1);
    chk("t5_winner", winner, 2'b10);
    cycle(1, 0, 0);
    chk("t5_again", {lscore, rscore, timecount, playing, game_over},
        {7'd0, 7'd0, 7'(GS), 1'b1, 1'b0});

    // 6: async reset mid-PAUSE
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", {lscore, rscore, timecount, playing, game_over, winner}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0);
    chk("t6_playing", playing, 1);
    chk("t6_time", timecount, GS);
    repeat (12) cycle(0, 0, 0);
    chk("t6_time12", timecount, 7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
